// File: rtl/sha256_pad_pkg.sv
// Shared constants and enums for the multi-block SHA256 padder.
package sha256_pad_pkg;
    localparam int SHA256_BLOCK_BITS = 512;
    localparam int BYTES_PER_BLOCK   = 64;
    localparam int LEN_FIELD_BYTES   = 8;
    localparam logic [7:0] PAD_BYTE  = 8'h80;

    // IDLE: wait for go | FILL: 64 slots + capture drain | PRESENT: block held until ack | ERR: len_err pulse
    typedef enum logic [1:0] {IDLE, FILL, PRESENT, ERR} pad_state_e;

    typedef enum logic [1:0] {SLOT_DATA, SLOT_PAD, SLOT_ZERO, SLOT_LEN} slot_type_e;
endpackage

// File: rtl/pad_slot_classify.sv
// Decides what byte slot k of block blk holds for a message of len_i bytes spread over nblk_i blocks.
module pad_slot_classify
    import sha256_pad_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int BLK_W = 3
) (
    input  logic [BLK_W-1:0] blk_i,
    input  logic [5:0]       k_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [BLK_W-1:0] nblk_i,
    output slot_type_e       slot_o,
    output logic [2:0]       len_sel_o
);
    localparam int P_W = ((BLK_W + 6) > LEN_W) ? (BLK_W + 6) : LEN_W;

    logic [P_W-1:0] pos;
    logic [P_W-1:0] len_ext;
    logic           last_blk;

    assign pos      = P_W'({blk_i, k_i});
    assign len_ext  = P_W'(len_i);
    assign last_blk = (blk_i == nblk_i - BLK_W'(1));
    // Length slots are k=56..63, so the byte select is simply k's low bits.
    assign len_sel_o = k_i[2:0];

    always_comb begin
        slot_o = SLOT_ZERO;
        if (pos < len_ext) begin
            slot_o = SLOT_DATA;
        end else if (pos == len_ext) begin
            slot_o = SLOT_PAD;
        end else if (last_blk && (k_i >= 6'd56)) begin
            slot_o = SLOT_LEN;
        end
    end
endmodule

// File: rtl/gen_padded_multiblock.sv
// Multi-block SHA256 padder: streams message bytes from SRAM, one slot per cycle,
// and presents each padded 512-bit block with a ready/ack handshake.
module gen_padded_multiblock
    import sha256_pad_pkg::*;
#(
    parameter  int MAX_MESSAGE_LENGTH = 247,
    parameter  int SYMBOL_WIDTH       = 8,
    localparam int MAX_BLOCKS = (MAX_MESSAGE_LENGTH + LEN_FIELD_BYTES) / BYTES_PER_BLOCK + 1,
    localparam int LEN_W      = $clog2(MAX_MESSAGE_LENGTH + 1),
    localparam int ADDR_W     = $clog2(MAX_MESSAGE_LENGTH),
    localparam int BLK_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         main_go_sig,
    input  logic [LEN_W-1:0]             msg_len,
    input  logic [SYMBOL_WIDTH-1:0]      msg_mem_data,
    input  logic                         pad_ack,
    output logic                         regop_msg_mem_en,
    output logic [ADDR_W-1:0]            regop_msg_mem_addr,
    output logic [SHA256_BLOCK_BITS-1:0] regop_pad_reg,
    output logic                         regop_pad_rdy,
    output logic [BLK_W-1:0]             regop_blk_idx,
    output logic                         regop_last_blk,
    output logic                         regop_busy,
    output logic                         regop_len_err
);
    if (SYMBOL_WIDTH != 8) begin : g_bad_symbol_width
        $error("gen_padded_multiblock: SYMBOL_WIDTH must be 8");
    end

    pad_state_e                   state_q, state_d;
    logic [LEN_W-1:0]             len_q, len_d;
    logic [BLK_W-1:0]             nblk_q, nblk_d;
    logic [BLK_W-1:0]             blk_q, blk_d;
    logic [5:0]                   k_q, k_d;
    logic                         issue_q, issue_d;
    logic                         en_q, en_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [5:0]                   s1_k_q, s1_k_d, s2_k_q, s2_k_d;
    logic                         s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [7:0]                   s1_byte_q, s1_byte_d, s2_byte_q, s2_byte_d;
    logic [SHA256_BLOCK_BITS-1:0] pad_q, pad_d;
    logic                         rdy_q, rdy_d;
    logic                         last_q, last_d;
    logic                         busy_q, busy_d;
    logic                         err_q, err_d;

    slot_type_e slot;
    logic [2:0] len_sel;
    logic [63:0] len_bits;
    logic        final_blk;

    pad_slot_classify #(.LEN_W(LEN_W), .BLK_W(BLK_W)) u_classify (
        .blk_i     (blk_q),
        .k_i       (k_q),
        .len_i     (len_q),
        .nblk_i    (nblk_q),
        .slot_o    (slot),
        .len_sel_o (len_sel)
    );

    assign len_bits  = 64'(len_q) << 3;
    assign final_blk = (blk_q == nblk_q - BLK_W'(1));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        nblk_d    = nblk_q;
        blk_d     = blk_q;
        k_d       = k_q;
        issue_d   = issue_q;
        en_d      = 1'b0;
        addr_d    = addr_q;
        s1_vld_d  = 1'b0;
        s1_k_d    = s1_k_q;
        s1_data_d = 1'b0;
        s1_byte_d = s1_byte_q;
        s2_vld_d  = s1_vld_q;
        s2_k_d    = s1_k_q;
        s2_data_d = s1_data_q;
        s2_byte_d = s1_byte_q;
        pad_d     = pad_q;
        rdy_d     = rdy_q;
        last_d    = last_q;
        busy_d    = busy_q;
        err_d     = 1'b0;

        // Slot bytes land two cycles after issue: one for the SRAM's registered read, one for capture.
        if (s2_vld_q) begin
            pad_d[{~s2_k_q, 3'b000} +: 8] = s2_data_q ? msg_mem_data[7:0] : s2_byte_q;
        end

        case (state_q)
            IDLE: begin
                if (main_go_sig) begin
                    if (32'(msg_len) > 32'(MAX_MESSAGE_LENGTH)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        len_d   = msg_len;
                        nblk_d  = BLK_W'((32'(msg_len) + 32'(LEN_FIELD_BYTES)) / 32'(BYTES_PER_BLOCK) + 32'd1);
                        blk_d   = '0;
                        pad_d   = '0;
                        busy_d  = 1'b1;
                        k_d     = '0;
                        issue_d = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            FILL: begin
                if (issue_q) begin
                    s1_vld_d  = 1'b1;
                    s1_k_d    = k_q;
                    s1_data_d = (slot == SLOT_DATA);
                    en_d      = (slot == SLOT_DATA);
                    if (slot == SLOT_DATA) begin
                        addr_d = ADDR_W'({blk_q, k_q});
                    end
                    case (slot)
                        SLOT_PAD: s1_byte_d = PAD_BYTE;
                        SLOT_LEN: s1_byte_d = len_bits[{~len_sel, 3'b000} +: 8];
                        default:  s1_byte_d = 8'h00;
                    endcase
                    k_d = k_q + 6'd1;
                    if (k_q == 6'd63) begin
                        issue_d = 1'b0;
                    end
                end
                if (s2_vld_q && (s2_k_q == 6'd63)) begin
                    rdy_d   = 1'b1;
                    last_d  = final_blk;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (pad_ack) begin
                    rdy_d  = 1'b0;
                    last_d = 1'b0;
                    if (!final_blk) begin
                        blk_d   = blk_q + BLK_W'(1);
                        pad_d   = '0;
                        k_d     = '0;
                        issue_d = 1'b1;
                        state_d = FILL;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            nblk_q    <= '0;
            blk_q     <= '0;
            k_q       <= '0;
            issue_q   <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_k_q    <= '0;
            s1_data_q <= 1'b0;
            s1_byte_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_k_q    <= '0;
            s2_data_q <= 1'b0;
            s2_byte_q <= '0;
            pad_q     <= '0;
            rdy_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            nblk_q    <= nblk_d;
            blk_q     <= blk_d;
            k_q       <= k_d;
            issue_q   <= issue_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            s1_vld_q  <= s1_vld_d;
            s1_k_q    <= s1_k_d;
            s1_data_q <= s1_data_d;
            s1_byte_q <= s1_byte_d;
            s2_vld_q  <= s2_vld_d;
            s2_k_q    <= s2_k_d;
            s2_data_q <= s2_data_d;
            s2_byte_q <= s2_byte_d;
            pad_q     <= pad_d;
            rdy_q     <= rdy_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign regop_msg_mem_en   = en_q;
    assign regop_msg_mem_addr = addr_q;
    assign regop_pad_reg      = pad_q;
    assign regop_pad_rdy      = rdy_q;
    assign regop_blk_idx      = blk_q;
    assign regop_last_blk     = last_q;
    assign regop_busy         = busy_q;
    assign regop_len_err      = err_q;
endmodule

// File: doc/gen_padded_multiblock.md
Name: gen_padded_multiblock

Overview:
- Successor to the single-block SHA256 padder.
- Reads a message of up to MAX_MESSAGE_LENGTH bytes from the message SRAM, one byte per cycle.
- Emits one or more 512-bit padded SHA256 blocks, each presented with a ready/ack handshake, to the downstream compression core.
- Removes the 55-byte single-block limit and adds block indexing, last-block marking, a length error and back-pressure.

Parameters:
- MAX_MESSAGE_LENGTH, 247, maximum message length in bytes. The supported range 1..2^61-1 is bounded in practice by SRAM depth.
- SYMBOL_WIDTH, 8, SRAM data width. Only 8 is legal; any other value is an elaboration error.
- MAX_BLOCKS, (MAX_MESSAGE_LENGTH+8)/64+1, derived maximum block count. Not overridable.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- main_go_sig  in  1  start request; sampled only in IDLE.
- msg_len  in  $clog2(MAX_MESSAGE_LENGTH+1)  message length in bytes; latched on an accepted go.
- msg_mem_data  in  SYMBOL_WIDTH  SRAM read data; valid one cycle after the enable/address.
- pad_ack  in  1  downstream accepts the presented block.
- regop_msg_mem_en  out  1  SRAM read enable, registered.
- regop_msg_mem_addr  out  $clog2(MAX_MESSAGE_LENGTH)  SRAM byte address (absolute byte index), registered.
- regop_pad_reg  out  512  padded block, registered. First message byte is in bits [511:504].
- regop_pad_rdy  out  1  block valid, registered.
- regop_blk_idx  out  $clog2(MAX_BLOCKS+1)  index of the presented block, starting at 0.
- regop_last_blk  out  1  presented block is the final one.
- regop_busy  out  1  high from the accepted go until the last ack.
- regop_len_err  out  1  one-cycle pulse when msg_len > MAX_MESSAGE_LENGTH at go.

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs are 0, including regop_pad_reg.
  - Any in-flight block is discarded; no partial rdy is produced.
- FSM states: IDLE, FILL, PRESENT, ERR.
- IDLE:
  - main_go_sig=1 with msg_len ≤ MAX: latch L=msg_len, compute N=(L+8)/64+1, clear blk, clear pad_reg, set busy, go to FILL.
  - main_go_sig=1 with msg_len > MAX: go to ERR.
- ERR: pulse regop_len_err for one cycle, produce no block, return to IDLE.
- FILL:
  - A 6-bit slot counter k runs 0..63, one slot per cycle, regardless of slot type.
  - Absolute byte position p = 64·blk + k.
  - Slot types:
    - p < L: data. Assert en with addr=p; write the byte to pad_reg byte k in the following cycle (one-stage capture pipeline).
    - p == L: write 8'h80.
    - p > L and not a length slot: 8'h00.
    - Last block, k = 56..63: byte (k−56) of the 64-bit big-endian value L·8.
  - en is asserted only for data slots and is 0 otherwise.
  - After k=63 plus one pipeline cycle, set pad_rdy and go to PRESENT.
- Latency:
  - From go sampled at edge E0, pad_rdy is high after edge E66.
  - From a non-final ack sampled at edge A0, the next pad_rdy is high after A0+66.
  - Latency is constant and independent of L.
- PRESENT:
  - pad_reg, blk_idx and last_blk are held stable while pad_rdy=1.
  - pad_ack=1 clears pad_rdy at that edge.
    - If blk < N−1: blk++, clear pad_reg, enter FILL.
    - Otherwise: clear busy and last_blk, enter IDLE.
- last_blk = (blk == N−1) while pad_rdy=1.
- Boundaries:
  - L mod 64 ∈ 56..63: the 0x80 byte stays in the data block, and the length goes to an extra all-zero block.
  - L=0: one block, 0x80 then zeros, length 0.
- Ignored inputs:
  - go while busy is ignored.
  - pad_ack outside PRESENT is ignored.
  - msg_len changes after the latch have no effect.
- go and ack in the same cycle in PRESENT of the final block: the ack is honoured and the go is ignored. A go is accepted only in IDLE.

Decomposition:
- Package sha256_pad_pkg holds:
  - SHA256_BLOCK_BITS=512, BYTES_PER_BLOCK=64, LEN_FIELD_BYTES=8, PAD_BYTE=8'h80.
  - The state typedef {IDLE, FILL, PRESENT, ERR}.
  - The slot-type enum {SLOT_DATA, SLOT_PAD, SLOT_ZERO, SLOT_LEN}.
- One sub-module, pad_slot_classify: combinational. Inputs blk, k, L, N; outputs slot type and length-byte select.

Test Plan:
- L=55 with message55.dat, immediate ack:
  - One block; rdy after E66; last_blk=1.
  - Byte55=0x80; last 64 bits = 0x1B8.
  - en asserted for exactly 55 cycles.
- L=56:
  - Block0: bytes 0..55 are data, byte56=0x80, bytes 57..63 = 0.
  - Block1: all zero except last 64 bits = 0x1C0; last_blk only on block1.
- L=0:
  - One block = 0x80 followed by 63 zero bytes.
  - en never asserted.
- L=247 (max), ack delayed 10 cycles per block:
  - Four blocks, blk_idx 0..3, pad_reg stable during the waits.
  - Block3 byte55=0x80; length = 0x7B8.
- Error and ignored inputs:
  - msg_len=248 → len_err pulses for one cycle, no rdy, busy stays 0.
  - go held high throughout L=56 → exactly 2 blocks produced, then a new run starts on the next go in IDLE.
- Reset mid-operation:
  - Reset asserted at slot k=30 of block1 (L=100) → all outputs 0 immediately.
  - A subsequent go with L=3 produces a correct single block with no residue from the aborted run.
